// File: rtl/add2_accumulator.sv
// Accumulates N_OPS sums of 2-bit operand pairs into an ACC_W-bit wrapping accumulator.
// A sticky ovf flag records any wrap; the result is held until the consumer handshakes it.
module add2_accumulator #(
  parameter int N_OPS = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_OPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic [ACC_W:0]   acc_sum;

  function automatic logic [ACC_W:0] pair_sum(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return {{(ACC_W-2){1'b0}}, s};
  endfunction

  // Extra top bit of the result is the carry out of bit ACC_W-1.
  function automatic logic [ACC_W:0] wrap_add(input logic [ACC_W-1:0] base,
                                              input logic [ACC_W:0]   inc);
    return {1'b0, base} + inc;
  endfunction

  assign accept    = (state == ACCUM) && in_valid;
  assign acc_sum   = wrap_add(acc, pair_sum(a, b));
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (accept && (cnt == LAST_IDX)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers hold their value through DONE and IDLE until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if ((state == IDLE) && start) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_sum[ACC_W-1:0];
      ovf <= ovf | acc_sum[ACC_W];
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_add2_accumulator.sv
// Directed bench for add2_accumulator: three parameterisations share one stimulus stream and are
// compared every cycle against a run-level arithmetic model, plus hand-computed literal checks.
module tb_add2_accumulator;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       start     = 1'b0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] a         = 2'd0;
  logic [1:0] b         = 2'd0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance 0: N_OPS=4 ACC_W=8, instance 1: N_OPS=4 ACC_W=4, instance 2: N_OPS=1 ACC_W=8
  logic       ir_a, ov_a, ovf_a, busy_a;
  logic [7:0] acc_a;
  logic       ir_b, ov_b, ovf_b, busy_b;
  logic [3:0] acc_b;
  logic       ir_c, ov_c, ovf_c, busy_c;
  logic [7:0] acc_c;

  add2_accumulator #(.N_OPS(4), .ACC_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ir_a),
    .a(a), .b(b), .out_valid(ov_a), .out_ready(out_ready), .acc(acc_a), .ovf(ovf_a), .busy(busy_a));

  add2_accumulator #(.N_OPS(4), .ACC_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ir_b),
    .a(a), .b(b), .out_valid(ov_b), .out_ready(out_ready), .acc(acc_b), .ovf(ovf_b), .busy(busy_b));

  add2_accumulator #(.N_OPS(1), .ACC_W(8)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ir_c),
    .a(a), .b(b), .out_valid(ov_c), .out_ready(out_ready), .acc(acc_c), .ovf(ovf_c), .busy(busy_c));

  logic [15:0] d_acc[3];
  logic        d_ovf[3];
  logic        d_ov[3];
  logic        d_ir[3];
  logic        d_busy[3];

  always_comb begin
    d_acc[0] = 16'(acc_a); d_ovf[0] = ovf_a; d_ov[0] = ov_a; d_ir[0] = ir_a; d_busy[0] = busy_a;
    d_acc[1] = 16'(acc_b); d_ovf[1] = ovf_b; d_ov[1] = ov_b; d_ir[1] = ir_b; d_busy[1] = busy_b;
    d_acc[2] = 16'(acc_c); d_ovf[2] = ovf_c; d_ov[2] = ov_c; d_ir[2] = ir_c; d_busy[2] = busy_c;
  end

  function automatic int nops_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int accw_of(input int i);
    return (i == 1) ? 4 : 8;
  endfunction

  // Run-level model: phase 0 waiting for start, 1 collecting pairs, 2 holding result
  int macc[3] = '{0, 0, 0};
  bit movf[3] = '{1'b0, 1'b0, 1'b0};
  int mcnt[3] = '{0, 0, 0};
  int mph[3]  = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mph[i]  <= 0;
        macc[i] <= 0;
        movf[i] <= 1'b0;
        mcnt[i] <= 0;
      end else begin
        case (mph[i])
          0: if (start) begin
            mph[i]  <= 1;
            macc[i] <= 0;
            movf[i] <= 1'b0;
            mcnt[i] <= 0;
          end
          1: if (in_valid) begin
            macc[i] <= (macc[i] + int'(a) + int'(b)) % (1 << accw_of(i));
            movf[i] <= movf[i] | ((macc[i] + int'(a) + int'(b)) >= (1 << accw_of(i)));
            mcnt[i] <= mcnt[i] + 1;
            if (mcnt[i] + 1 == nops_of(i)) mph[i] <= 2;
          end
          default: if (out_ready) mph[i] <= 0;
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dut%0d.acc", i),       int'(d_acc[i]),  macc[i]);
      chk($sformatf("dut%0d.ovf", i),       int'(d_ovf[i]),  int'(movf[i]));
      chk($sformatf("dut%0d.out_valid", i), int'(d_ov[i]),   (mph[i] == 2) ? 1 : 0);
      chk($sformatf("dut%0d.in_ready", i),  int'(d_ir[i]),   (mph[i] == 1) ? 1 : 0);
      chk($sformatf("dut%0d.busy", i),      int'(d_busy[i]), (mph[i] != 0) ? 1 : 0);
    end
  end

  task automatic cyc(input logic s, input logic v, input logic [1:0] x, input logic [1:0] y,
                     input logic r);
    start = s; in_valid = v; a = x; b = y; out_ready = r;
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  logic [6:0] gap_pat;

  initial begin
    gap_pat = 7'b1101001;

    #1 rst_n = 1'b0;
    #1;
    chk("reset.acc", int'(acc_a), 0);
    chk("reset.ovf", int'(ovf_a), 0);
    chk("reset.busy", int'(busy_a), 0);
    chk("reset.in_ready", int'(ir_a), 0);
    chk("reset.out_valid", int'(ov_a), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic run, back-to-back pairs
    cyc(1, 0, 0, 0, 0);
    chk("run1.busy", int'(busy_a), 1);
    chk("run1.in_ready", int'(ir_a), 1);
    cyc(0, 1, 3, 3, 0);
    cyc(0, 1, 1, 2, 0);
    cyc(0, 1, 0, 0, 0);
    chk("run1.not_done_after_3", int'(ov_a), 0);
    cyc(0, 1, 2, 1, 0);
    chk("run1.out_valid", int'(ov_a), 1);
    chk("run1.acc", int'(acc_a), 12);
    chk("run1.ovf", int'(ovf_a), 0);
    chk("run1.acc_w4", int'(acc_b), 12);
    chk("run1.acc_n1", int'(acc_c), 6);
    cyc(0, 0, 0, 0, 1);
    chk("run1.idle_busy", int'(busy_a), 0);
    chk("run1.idle_acc_kept", int'(acc_a), 12);

    // Wrap on the narrow accumulator
    cyc(1, 0, 0, 0, 0);
    repeat (4) cyc(0, 1, 3, 3, 0);
    chk("wrap.acc_w4", int'(acc_b), 8);
    chk("wrap.ovf_w4", int'(ovf_b), 1);
    chk("wrap.out_valid_w4", int'(ov_b), 1);
    chk("wrap.acc_w8", int'(acc_a), 24);
    chk("wrap.ovf_w8", int'(ovf_a), 0);
    cyc(0, 0, 0, 0, 1);

    // Backpressure with a stray start while holding the result
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 1, 0, 0);
    chk("bp.acc", int'(acc_a), 5);
    for (int k = 0; k < 5; k++) begin
      cyc(k == 2, 0, 0, 0, 0);
      chk("bp.hold_valid", int'(ov_a), 1);
      chk("bp.hold_acc", int'(acc_a), 5);
    end
    cyc(0, 0, 0, 0, 1);
    chk("bp.released_busy", int'(busy_a), 0);
    chk("bp.released_valid", int'(ov_a), 0);
    cyc(0, 0, 0, 0, 0);
    chk("bp.stray_start_ignored", int'(busy_a), 0);

    // Gaps in in_valid
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      cyc(0, gap_pat[k], 1, 1, 0);
      if (k == 5) chk("gap.not_done_after_6", int'(ov_a), 0);
    end
    chk("gap.done_after_7", int'(ov_a), 1);
    chk("gap.acc", int'(acc_a), 8);
    cyc(0, 0, 0, 0, 1);

    // Asynchronous reset mid-run
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.acc", int'(acc_a), 0);
    chk("arst.ovf", int'(ovf_a), 0);
    chk("arst.busy", int'(busy_a), 0);
    chk("arst.in_ready", int'(ir_a), 0);
    chk("arst.out_valid", int'(ov_a), 0);
    chk("arst.out_valid_n1", int'(ov_c), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 1, 3, 3, 0);
    cyc(0, 1, 3, 3, 0);
    chk("arst.no_start_in_ready", int'(ir_a), 0);
    chk("arst.no_start_acc", int'(acc_a), 0);
    chk("arst.no_start_busy", int'(busy_a), 0);

    // Single-pair run, start coincident with the result handshake
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 2, 3, 0);
    chk("n1.out_valid", int'(ov_c), 1);
    chk("n1.acc", int'(acc_c), 5);
    cyc(1, 0, 0, 0, 1);
    chk("n1.handshake_idle", int'(busy_c), 0);
    chk("n1.handshake_valid", int'(ov_c), 0);
    cyc(0, 0, 0, 0, 0);
    chk("n1.no_new_run", int'(busy_c), 0);
    chk("n1.acc_kept", int'(acc_c), 5);
    chk("n1.accum_start_ignored_busy", int'(busy_a), 1);
    chk("n1.accum_start_ignored_acc", int'(acc_a), 5);

    repeat (2) cyc(0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
